// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared helpers for the async FIFO pointer controllers
// Purpose: Gray/binary conversion functions and depth helper, shared by the
//          write-side and read-side pointer controllers.
// Ports:   none (package)
package async_fifo_pkg;

   // Widest pointer the conversion helpers handle; callers zero-extend into
   // this width and truncate the result back to their own width.
   localparam int GRAY_MAX_W = 32;

   function automatic int depth_of(input int ptr_w);
      return 1 << ptr_w;
   endfunction

   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] v);
      return v ^ (v >> 1);
   endfunction

   // Zero-extended upper bits decode to zero, so the prefix XOR from the top
   // stays correct for any narrower width.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] v);
      logic [GRAY_MAX_W-1:0] b;
      b[GRAY_MAX_W-1] = v[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ v[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/graycode_decoder.sv
// rtl/graycode_decoder.sv - combinational Gray-to-binary decoder
// Purpose: Gray to binary conversion, width-generic; bit i is the XOR of
//          bits width-1 down to i.
// Ports:   gray in  [width-1:0] Gray-coded value
//          bin  out [width-1:0] binary value
module graycode_decoder
   import async_fifo_pkg::*;
#(
   parameter int width = 4
) (
   input  logic [width-1:0] gray,
   output logic [width-1:0] bin
);

   assign bin = width'(gray2bin(GRAY_MAX_W'(gray)));

endmodule

// File: rtl/graycode_encoder.sv
// rtl/graycode_encoder.sv - combinational binary-to-Gray encoder
// Purpose: binary to Gray conversion, width-generic.
// Ports:   bin  in  [width-1:0] binary value
//          gray out [width-1:0] Gray-coded value
module graycode_encoder
   import async_fifo_pkg::*;
#(
   parameter int width = 4
) (
   input  logic [width-1:0] bin,
   output logic [width-1:0] gray
);

   assign gray = width'(bin2gray(GRAY_MAX_W'(bin)));

endmodule

// File: rtl/async_fifo_write_ctrl.sv
// rtl/async_fifo_write_ctrl.sv - write-side pointer controller for the async FIFO
// Purpose: generates RAM write strobe/address, the registered Gray write
//          pointer for the read-domain synchroniser, and registered full,
//          almost_full, fill level and sticky overflow flags.
// Ports:   clk_tx, rst_tx (async, active-high)      clock / reset
//          push, clr_overflow                       write request / overflow clear
//          synced_graycoded_read_pointer [PTR_W:0]  read pointer, already in clk_tx
//          write_en, write_pointer [PTR_W-1:0]      RAM write strobe / address
//          graycoded_write_pointer [PTR_W:0]        to read-domain synchroniser
//          full, almost_full, wr_level [PTR_W:0], overflow  status
module async_fifo_write_ctrl
   import async_fifo_pkg::*;
#(
   parameter int PTR_W     = 3,
   parameter int AF_THRESH = 6
) (
   input  logic             clk_tx,
   input  logic             rst_tx,
   input  logic             push,
   input  logic             clr_overflow,
   input  logic [PTR_W:0]   synced_graycoded_read_pointer,
   output logic             write_en,
   output logic [PTR_W-1:0] write_pointer,
   output logic [PTR_W:0]   graycoded_write_pointer,
   output logic             full,
   output logic             almost_full,
   output logic [PTR_W:0]   wr_level,
   output logic             overflow
);

   localparam int            CW       = PTR_W + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(depth_of(PTR_W));
   localparam logic [CW-1:0] THRESH_C = CW'(AF_THRESH);

   logic [CW-1:0] wr_bin_q, wr_bin_d;
   logic [CW-1:0] wr_gray_q, wr_gray_d;
   logic          full_q, full_d;
   logic          almost_full_q, almost_full_d;
   logic [CW-1:0] wr_level_q, wr_level_d;
   logic          overflow_q, overflow_d;

   logic [CW-1:0] wr_gray_next;
   logic [CW-1:0] rd_bin;
   logic [CW-1:0] level_next;
   logic          accept;

   assign accept = push & ~full_q;

   graycode_encoder #(.width(CW)) u_wr_gray_enc (
      .bin  (wr_bin_d),
      .gray (wr_gray_next)
   );

   graycode_decoder #(.width(CW)) u_rd_gray_dec (
      .gray (synced_graycoded_read_pointer),
      .bin  (rd_bin)
   );

   always_comb begin
      wr_bin_d      = wr_bin_q + CW'(accept);
      wr_gray_d     = wr_gray_next;
      // Extra MSB is the lap bit, so plain modulo subtraction gives 0..DEPTH
      // across the counter wrap.
      level_next    = wr_bin_d - rd_bin;
      // Full in the Gray domain: top two bits inverted, the rest equal.
      full_d        = (wr_gray_next[PTR_W:PTR_W-1] == ~synced_graycoded_read_pointer[PTR_W:PTR_W-1])
                   && (wr_gray_next[PTR_W-2:0] == synced_graycoded_read_pointer[PTR_W-2:0]);
      almost_full_d = (level_next >= THRESH_C);
      wr_level_d    = level_next;
      // Set wins over clear when both happen in the same cycle.
      overflow_d    = (push & full_q) | (overflow_q & ~clr_overflow);
   end

   always_ff @(posedge clk_tx or posedge rst_tx) begin
      if (rst_tx) begin
         wr_bin_q      <= '0;
         wr_gray_q     <= '0;
         full_q        <= 1'b0;
         almost_full_q <= 1'b0;
         wr_level_q    <= '0;
         overflow_q    <= 1'b0;
      end else begin
         wr_bin_q      <= wr_bin_d;
         wr_gray_q     <= wr_gray_d;
         full_q        <= full_d;
         almost_full_q <= almost_full_d;
         wr_level_q    <= wr_level_d;
         overflow_q    <= overflow_d;
      end
   end

   assign write_en                = accept;
   assign write_pointer           = wr_bin_q[PTR_W-1:0];
   assign graycoded_write_pointer = wr_gray_q;
   assign full                    = full_q;
   assign almost_full             = almost_full_q;
   assign wr_level                = wr_level_q;
   assign overflow                = overflow_q;

   // A read pointer ahead of the written data, or more than DEPTH behind,
   // means the read side is broken; the counter arithmetic cannot recover it.
   a_level_legal: assert property (@(posedge clk_tx) disable iff (rst_tx) level_next <= DEPTH_C);

endmodule
